// File: rtl/i4001_rom_if.sv
// rtl/i4001_rom_if.sv - CPU-side bus bundle between the i4004 and one i4001 ROM
interface i4001_rom_if;
    logic       sync;
    logic       cm_rom;
    logic [3:0] dbus_in;
    logic [3:0] ibus;
    logic [3:0] dbus_out;
    logic       dbus_oe;

    modport master (
        output sync,
        output cm_rom,
        output dbus_in,
        output ibus,
        input  dbus_out,
        input  dbus_oe
    );

    modport slave (
        input  sync,
        input  cm_rom,
        input  dbus_in,
        input  ibus,
        output dbus_out,
        output dbus_oe
    );
endinterface

// File: rtl/i4001_rom.sv
// rtl/i4001_rom.sv - MCS-4 256x8 program ROM with one 4-bit port; port logic under I4001_ROM_IO_EN
module i4001_rom #(
    parameter logic [3:0] CHIP_ID   = 4'h0,
    parameter string      INIT_FILE = "",
    parameter logic [3:0] IO_MASK   = 4'b0000
) (
    input  logic            clk,
    input  logic            rst,
    i4001_rom_if.slave      bus,
    input  logic [3:0]      io_in,
    output logic [3:0]      io_out,
    input  logic            prog_we,
    input  logic [7:0]      prog_addr,
    input  logic [7:0]      prog_data
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_A1, ST_A2, ST_A3, ST_M1, ST_M2, ST_X1, ST_X2, ST_X3
    } phase_t;

    phase_t     state_q, state_d;
    logic [3:0] addr_lo_q, addr_lo_d;
    logic [3:0] addr_hi_q, addr_hi_d;
    logic       sel_q, sel_d;
    logic [7:0] byte_q, byte_d;
    logic [3:0] dbus_out_q, dbus_out_d;
    logic       dbus_oe_q, dbus_oe_d;
    logic       id_match;
    logic       rd_en;
    logic       rdr_hit;
    logic [3:0] rdr_data;

    logic [7:0] mem [256];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    end

    // Program-load port is independent of the fetch phase; a read in the
    // same cycle sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (prog_we) mem[prog_addr] <= prog_data;
    end

    assign id_match = (bus.dbus_in == CHIP_ID);
    assign rd_en    = (state_q == ST_A3) && id_match;

`ifdef I4001_ROM_IO_EN
    logic       src_sel_q, src_sel_d;
    logic       io_pend_q, io_pend_d;
    logic [3:0] io_op_q, io_op_d;
    logic [3:0] io_out_q, io_out_d;

    always_comb begin
        src_sel_d = src_sel_q;
        io_pend_d = io_pend_q;
        io_op_d   = io_op_q;
        io_out_d  = io_out_q;
        if (state_q == ST_M2) begin
            if (bus.cm_rom) begin
                io_op_d   = bus.ibus;
                io_pend_d = 1'b1;
            end else begin
                io_pend_d = 1'b0;
            end
        end
        // WRR uses the selection from the previous SRC, before this X2 can change it.
        if (state_q == ST_X2) begin
            if (io_pend_q && src_sel_q && (io_op_q == 4'h2))
                io_out_d = bus.dbus_in & ~IO_MASK;
            if (bus.cm_rom)
                src_sel_d = id_match;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_sel_q <= 1'b0;
            io_pend_q <= 1'b0;
            io_op_q   <= 4'h0;
            io_out_q  <= 4'h0;
        end else begin
            src_sel_q <= src_sel_d;
            io_pend_q <= io_pend_d;
            io_op_q   <= io_op_d;
            io_out_q  <= io_out_d;
        end
    end

    assign rdr_hit  = io_pend_q && src_sel_q && (io_op_q == 4'hA);
    assign rdr_data = (io_in & IO_MASK) | (io_out_q & ~IO_MASK);
    assign io_out   = io_out_q;
`else
    logic unused_io;
    assign unused_io = ^{io_in, bus.ibus, bus.cm_rom};
    assign rdr_hit   = 1'b0;
    assign rdr_data  = 4'h0;
    assign io_out    = 4'h0;
`endif

    always_comb begin
        state_d    = state_q;
        addr_lo_d  = addr_lo_q;
        addr_hi_d  = addr_hi_q;
        sel_d      = sel_q;
        byte_d     = byte_q;
        dbus_out_d = 4'h0;
        dbus_oe_d  = 1'b0;

        if (bus.sync) begin
            state_d = ST_A1;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_A1:   state_d = ST_A2;
                ST_A2:   state_d = ST_A3;
                ST_A3:   state_d = ST_M1;
                ST_M1:   state_d = ST_M2;
                ST_M2:   state_d = ST_X1;
                ST_X1:   state_d = ST_X2;
                ST_X2:   state_d = ST_X3;
                default: state_d = ST_IDLE;
            endcase
        end

        case (state_q)
            ST_A1:   addr_lo_d = bus.dbus_in;
            ST_A2:   addr_hi_d = bus.dbus_in;
            ST_A3:   sel_d     = id_match;
            default: ;
        endcase

        if (rd_en) byte_d = mem[{addr_hi_q, addr_lo_q}];

        // Bus outputs are registered, so they are chosen by the phase being entered.
        if (state_d == ST_M1 && rd_en) begin
            dbus_out_d = byte_d[7:4];
            dbus_oe_d  = 1'b1;
        end else if (state_d == ST_M2 && sel_q) begin
            dbus_out_d = byte_q[3:0];
            dbus_oe_d  = 1'b1;
        end else if (state_d == ST_X2 && rdr_hit) begin
            dbus_out_d = rdr_data;
            dbus_oe_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_lo_q  <= 4'h0;
            addr_hi_q  <= 4'h0;
            sel_q      <= 1'b0;
            byte_q     <= 8'h00;
            dbus_out_q <= 4'h0;
            dbus_oe_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_lo_q  <= addr_lo_d;
            addr_hi_q  <= addr_hi_d;
            sel_q      <= sel_d;
            byte_q     <= byte_d;
            dbus_out_q <= dbus_out_d;
            dbus_oe_q  <= dbus_oe_d;
        end
    end

    assign bus.dbus_out = dbus_out_q;
    assign bus.dbus_oe  = dbus_oe_q;

endmodule

// File: tb/tb_i4001_rom.sv
// tb/tb_i4001_rom.sv - two-chip i4001_rom bench with an instruction-level reference model
module tb_i4001_rom;
`ifdef I4001_ROM_IO_EN
    localparam bit IO_EN = 1'b1;
`else
    localparam bit IO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       sync;
    logic       cm_rom;
    logic [3:0] dbus_in;
    logic [3:0] io_in_v [2];
    logic       prog_we_v [2];
    logic [7:0] prog_addr;
    logic [7:0] prog_data;
    logic [3:0] io_out_a, io_out_b;
    wire  [3:0] ibus;

    always #5 clk = ~clk;

    i4001_rom_if bus_a ();
    i4001_rom_if bus_b ();

    assign bus_a.sync = sync;   assign bus_b.sync = sync;
    assign bus_a.cm_rom = cm_rom; assign bus_b.cm_rom = cm_rom;
    assign bus_a.dbus_in = dbus_in; assign bus_b.dbus_in = dbus_in;
    assign ibus = (bus_a.dbus_oe ? bus_a.dbus_out : 4'h0) | (bus_b.dbus_oe ? bus_b.dbus_out : 4'h0);
    assign bus_a.ibus = ibus;   assign bus_b.ibus = ibus;

    i4001_rom #(.CHIP_ID(4'h1), .INIT_FILE(""), .IO_MASK(4'b1100)) u_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave), .io_in(io_in_v[0]), .io_out(io_out_a),
        .prog_we(prog_we_v[0]), .prog_addr(prog_addr), .prog_data(prog_data)
    );
    i4001_rom #(.CHIP_ID(4'h2), .INIT_FILE(""), .IO_MASK(4'b0000)) u_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave), .io_in(io_in_v[1]), .io_out(io_out_b),
        .prog_we(prog_we_v[1]), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-chip memory image and port registers, per instruction.
    logic [7:0] mm [2][256];
    logic [3:0] cid [2];
    logic [3:0] cmask [2];
    logic       mt [2];
    logic [7:0] fb [2];
    logic       src_m [2], pend_m [2];
    logic [3:0] op_m [2], io_m [2];
    logic [3:0] exp_out [2], nx_out [2], exp_io [2];
    logic       exp_oe [2], nx_oe [2];
    logic       chk_en = 1'b0;
    logic       ob_oe [2][8];
    logic [3:0] ob_out [2][8];

    always @(negedge clk) begin
        if (chk_en) begin
            check("a_oe",  {7'b0, bus_a.dbus_oe}, {7'b0, exp_oe[0]});
            check("a_out", {4'b0, bus_a.dbus_out}, {4'b0, exp_out[0]});
            check("b_oe",  {7'b0, bus_b.dbus_oe}, {7'b0, exp_oe[1]});
            check("b_out", {4'b0, bus_b.dbus_out}, {4'b0, exp_out[1]});
            check("a_io",  {4'b0, io_out_a}, {4'b0, exp_io[0]});
            check("b_io",  {4'b0, io_out_b}, {4'b0, exp_io[1]});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            src_m[c] = 1'b0; pend_m[c] = 1'b0; op_m[c] = 4'h0; io_m[c] = 4'h0; mt[c] = 1'b0;
        end
    endtask

    task automatic settle_zero();
        for (int c = 0; c < 2; c++) begin
            exp_oe[c] = 1'b0; exp_out[c] = 4'h0; exp_io[c] = io_m[c];
        end
    endtask

    task automatic idle(input int n, input logic s_last);
        for (int i = 0; i < n; i++) begin
            sync = (i == n - 1) ? s_last : 1'b0;
            dbus_in = 4'($urandom);
            cm_rom = 1'($urandom);
            tick();
            settle_zero();
        end
        sync = 1'b0;
    endtask

    task automatic load(input int c, input logic [7:0] a, input logic [7:0] d);
        sync = 1'b0;
        prog_we_v[c] = 1'b1; prog_addr = a; prog_data = d;
        mm[c][a] = d;
        tick();
        prog_we_v[c] = 1'b0;
        settle_zero();
    endtask

    // One instruction cycle A1..X3; the caller has already driven sync in the cycle before.
    task automatic run_instr(input logic [11:0] a, input logic cmm2, input logic [3:0] x2,
                             input logic cmx2, input logic ns, input int pwe,
                             input logic [7:0] pa, input logic [7:0] pd, input int rst_at);
        logic       dead;
        logic [3:0] ib;
        dead = 1'b0;
        for (int k = 0; k < 8; k++) begin
            sync = (k == 7) ? ns : 1'b0;
            case (k)
                0: dbus_in = a[3:0];
                1: dbus_in = a[7:4];
                2: dbus_in = a[11:8];
                6: dbus_in = x2;
                default: dbus_in = 4'($urandom);
            endcase
            cm_rom = (k == 4) ? cmm2 : (k == 6) ? cmx2 : 1'($urandom);
            rst = (k == rst_at);
            prog_we_v[0] = (k == 2) && (pwe == 1);
            prog_we_v[1] = (k == 2) && (pwe == 2);
            prog_addr = pa; prog_data = pd;
            ob_oe[0][k] = bus_a.dbus_oe; ob_out[0][k] = bus_a.dbus_out;
            ob_oe[1][k] = bus_b.dbus_oe; ob_out[1][k] = bus_b.dbus_out;
            for (int c = 0; c < 2; c++) begin nx_oe[c] = 1'b0; nx_out[c] = 4'h0; end
            if (k == rst_at) begin
                model_reset();
                dead = 1'b1;
            end else if (!dead) begin
                case (k)
                    2: for (int c = 0; c < 2; c++) begin
                        mt[c] = (a[11:8] == cid[c]);
                        if (mt[c]) fb[c] = mm[c][a[7:0]];
                        nx_oe[c] = mt[c];
                        nx_out[c] = mt[c] ? fb[c][7:4] : 4'h0;
                    end
                    3: for (int c = 0; c < 2; c++) begin
                        nx_oe[c] = mt[c];
                        nx_out[c] = mt[c] ? fb[c][3:0] : 4'h0;
                    end
                    4: begin
                        ib = (mt[0] ? fb[0][3:0] : 4'h0) | (mt[1] ? fb[1][3:0] : 4'h0);
                        for (int c = 0; c < 2; c++) begin
                            if (IO_EN) begin
                                if (cmm2) begin op_m[c] = ib; pend_m[c] = 1'b1; end
                                else pend_m[c] = 1'b0;
                            end
                        end
                    end
                    5: for (int c = 0; c < 2; c++) begin
                        if (IO_EN && pend_m[c] && src_m[c] && op_m[c] == 4'hA) begin
                            nx_oe[c] = 1'b1;
                            nx_out[c] = (io_in_v[c] & cmask[c]) | (io_m[c] & ~cmask[c]);
                        end
                    end
                    6: for (int c = 0; c < 2; c++) begin
                        if (IO_EN) begin
                            if (pend_m[c] && src_m[c] && op_m[c] == 4'h2) io_m[c] = x2 & ~cmask[c];
                            if (cmx2) src_m[c] = (x2 == cid[c]);
                        end
                    end
                    default: ;
                endcase
            end
            if (k == 2 && pwe != 0) mm[pwe - 1][pa] = pd;
            tick();
            for (int c = 0; c < 2; c++) begin
                exp_oe[c] = nx_oe[c]; exp_out[c] = nx_out[c]; exp_io[c] = io_m[c];
            end
        end
        rst = 1'b0;
        prog_we_v[0] = 1'b0; prog_we_v[1] = 1'b0;
        sync = 1'b0;
    endtask

    initial begin
        logic [11:0] ra;
        int          pw, rat;
        logic        ns;
        rst = 1'b1; sync = 1'b0; cm_rom = 1'b0; dbus_in = 4'h0;
        prog_we_v[0] = 1'b0; prog_we_v[1] = 1'b0; prog_addr = 8'h00; prog_data = 8'h00;
        io_in_v[0] = 4'h0; io_in_v[1] = 4'h0;
        cid[0] = 4'h1; cid[1] = 4'h2; cmask[0] = 4'b1100; cmask[1] = 4'b0000;
        model_reset();
        settle_zero();
        repeat (3) tick();
        chk_en = 1'b1;
        check("reset_oe_a", {7'b0, bus_a.dbus_oe}, 8'h00);
        check("reset_out_b", {4'b0, bus_b.dbus_out}, 8'h00);
        check("reset_io_a", {4'b0, io_out_a}, 8'h00);
        rst = 1'b0;

        for (int i = 0; i < 256; i++) begin
            load(0, 8'(i), 8'($urandom));
            load(1, 8'(i), 8'($urandom));
        end
        load(0, 8'h34, 8'hD5);
        load(0, 8'h20, 8'hE2);
        load(0, 8'h21, 8'hEA);
        load(1, 8'h10, 8'hE2);

        // Fetch from chip 1
        idle(1, 1'b1);
        run_instr(12'h134, 1'b0, 4'h0, 1'b0, 1'b1, 0, 8'h00, 8'h00, -1);
        check("fetch_opr", {3'b0, ob_oe[0][3], ob_out[0][3]}, 8'h1D);
        check("fetch_opa", {3'b0, ob_oe[0][4], ob_out[0][4]}, 8'h15);
        check("fetch_x1_oe", {7'b0, ob_oe[0][5]}, 8'h00);
        check("fetch_b_quiet", {7'b0, ob_oe[1][3] | ob_oe[1][4]}, 8'h00);

        // Nobody selected
        run_instr(12'h334, 1'b0, 4'h0, 1'b0, 1'b1, 0, 8'h00, 8'h00, -1);
        check("desel_a", {7'b0, ob_oe[0][3] | ob_oe[0][4]}, 8'h00);
        check("desel_b", {7'b0, ob_oe[1][3] | ob_oe[1][4]}, 8'h00);

        // Program write in the A3 cycle of a fetch of the same address
        run_instr(12'h134, 1'b0, 4'h0, 1'b0, 1'b1, 1, 8'h34, 8'h71, -1);
        check("ld_old_opr", {3'b0, ob_oe[0][3], ob_out[0][3]}, 8'h1D);
        check("ld_old_opa", {3'b0, ob_oe[0][4], ob_out[0][4]}, 8'h15);
        run_instr(12'h134, 1'b0, 4'h0, 1'b0, 1'b1, 0, 8'h00, 8'h00, -1);
        check("ld_new_opr", {3'b0, ob_oe[0][3], ob_out[0][3]}, 8'h17);
        check("ld_new_opa", {3'b0, ob_oe[0][4], ob_out[0][4]}, 8'h11);

        // SRC chip 2, WRR 4'hA
        run_instr(12'h100, 1'b0, 4'h2, 1'b1, 1'b1, 0, 8'h00, 8'h00, -1);
        run_instr(12'h210, 1'b1, 4'hA, 1'b0, 1'b1, 0, 8'h00, 8'h00, -1);
        check("wrr_io_b", {4'b0, io_out_b}, IO_EN ? 8'h0A : 8'h00);
        check("wrr_io_a", {4'b0, io_out_a}, 8'h00);

        // SRC chip 1, WRR 3, then RDR with io_in=8 and mask 1100
        run_instr(12'h100, 1'b0, 4'h1, 1'b1, 1'b1, 0, 8'h00, 8'h00, -1);
        run_instr(12'h120, 1'b1, 4'h3, 1'b0, 1'b1, 0, 8'h00, 8'h00, -1);
        check("wrr_io_a3", {4'b0, io_out_a}, IO_EN ? 8'h03 : 8'h00);
        io_in_v[0] = 4'h8;
        run_instr(12'h121, 1'b1, 4'h0, 1'b0, 1'b1, 0, 8'h00, 8'h00, -1);
        check("rdr_x2", {3'b0, ob_oe[0][6], ob_out[0][6]}, IO_EN ? 8'h1B : 8'h00);
        check("rdr_x1_oe", {7'b0, ob_oe[0][5]}, 8'h00);
        check("rdr_x3_oe", {7'b0, ob_oe[0][7]}, 8'h00);

        // Lost sync at X3, then resync
        run_instr(12'h134, 1'b0, 4'h0, 1'b0, 1'b0, 0, 8'h00, 8'h00, -1);
        idle(4, 1'b0);
        idle(1, 1'b1);

        // Reset in M1
        run_instr(12'h134, 1'b0, 4'h0, 1'b0, 1'b1, 0, 8'h00, 8'h00, 3);
        check("rst_m1_opr", {3'b0, ob_oe[0][3], ob_out[0][3]}, 8'h17);
        check("rst_oe", {7'b0, ob_oe[0][4]}, 8'h00);
        check("rst_io", {4'b0, io_out_a}, 8'h00);

        for (int n = 0; n < 300; n++) begin
            ra = {4'($urandom_range(0, 3)), 8'($urandom)};
            if ($urandom_range(0, 3) == 0) pw = $urandom_range(1, 2); else pw = 0;
            rat = ($urandom_range(0, 39) == 0) ? $urandom_range(0, 6) : -1;
            ns = ($urandom_range(0, 7) != 0);
            io_in_v[0] = 4'($urandom); io_in_v[1] = 4'($urandom);
            run_instr(ra, ($urandom_range(0, 2) == 0), 4'($urandom), ($urandom_range(0, 3) == 0), ns,
                      pw, ($urandom_range(0, 1) == 0) ? ra[7:0] : 8'($urandom), 8'($urandom), rat);
            if (!ns) begin
                idle($urandom_range(1, 3), 1'b0);
                idle(1, 1'b1);
            end
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
